// File: rtl/conversor_int_float.sv
// conversor_int_float: iterative signed-integer to custom-float encoder.
// Normalizes one bit per clock; packs {sign, exp(bias 31), 25-bit fraction}.
`default_nettype none

module conversor_int_float (
  input  logic        clock_100kHz,
  input  logic        reset,
  input  logic        valid_in,
  input  logic [0:31] int_in,
  input  logic [0:5]  scale_in,
  output logic        ready_out,
  output logic        done_out,
  output logic [0:31] data_out,
  output logic [0:3]  status_out
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    NORMALIZE = 2'd1,
    PACK      = 2'd2
  } state_t;

  state_t      state, state_next;
  logic        sign, sign_next;
  logic [31:0] mag, mag_next;
  logic [5:0]  scale, scale_next;
  logic [4:0]  k, k_next;
  logic        done_next;
  logic [31:0] data_next;
  logic [3:0]  status_next;
  logic [31:0] int_word;
  logic [7:0]  exp_sum;

  assign int_word  = int_in;
  // 8-bit signed exponent: 62 - k + scale spans -1..93
  assign exp_sum   = 8'd62 - {3'd0, k} + {{2{scale[5]}}, scale};
  assign ready_out = (state == IDLE) && reset;

  always_ff @(posedge clock_100kHz or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      sign       <= 1'b0;
      mag        <= 32'd0;
      scale      <= 6'd0;
      k          <= 5'd0;
      done_out   <= 1'b0;
      data_out   <= 32'd0;
      status_out <= 4'd0;
    end else begin
      state      <= state_next;
      sign       <= sign_next;
      mag        <= mag_next;
      scale      <= scale_next;
      k          <= k_next;
      done_out   <= done_next;
      data_out   <= data_next;
      status_out <= status_next;
    end
  end

  always_comb begin
    state_next  = state;
    sign_next   = sign;
    mag_next    = mag;
    scale_next  = scale;
    k_next      = k;
    done_next   = 1'b0;
    data_next   = data_out;
    status_next = status_out;

    case (state)
      IDLE: begin
        if (valid_in) begin
          sign_next  = int_word[31];
          mag_next   = int_word[31] ? (~int_word + 32'd1) : int_word;
          scale_next = scale_in;
          k_next     = 5'd0;
          state_next = NORMALIZE;
        end
      end

      NORMALIZE: begin
        if ((mag == 32'd0) || mag[31]) begin
          state_next = PACK;
        end else begin
          mag_next = {mag[30:0], 1'b0};
          k_next   = k + 5'd1;
        end
      end

      PACK: begin
        done_next  = 1'b1;
        state_next = IDLE;
        // Zero drops the sign; overflow/underflow keep it
        if (mag == 32'd0) begin
          data_next   = 32'd0;
          status_next = 4'd0;
        end else if ($signed(exp_sum) >= 8'sd63) begin
          data_next   = {sign, 6'h3F, 25'd0};
          status_next = 4'd1;
        end else if ($signed(exp_sum) <= 8'sd0) begin
          data_next   = {sign, 31'd0};
          status_next = 4'd2;
        end else if (mag[5:0] != 6'd0) begin
          data_next   = {sign, exp_sum[5:0], mag[30:6]};
          status_next = 4'd3;
        end else begin
          data_next   = {sign, exp_sum[5:0], mag[30:6]};
          status_next = 4'd0;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire
